// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, UNROLL bits per cycle, sign fix-up at the end.
module ex_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int N = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2:0]          op_q, op_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                idle_like, accept, is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag, quo, rem;
    logic [2*XLEN-1:0]   p, prod;
    logic [XLEN:0]       sum, rr;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept    = start & ~flush & idle_like;
    assign is_div    = funct3[2];
    // MULHSU treats only rs1 as signed; MULHU and the unsigned divides treat neither.
    assign sgn_a     = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sgn_b     = is_div ? ~funct3[0] : ~funct3[1];
    assign a_neg     = sgn_a & op_a[XLEN-1];
    assign b_neg     = sgn_b & op_b[XLEN-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign div_zero  = (op_b == '0);
    assign div_ovf   = ~funct3[0] & (op_a == SMIN) & (op_b == '1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        p         = acc_q;
        sum       = '0;
        rr        = '0;
        prod      = neg_quo_q ? -acc_q : acc_q;
        quo       = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d      = funct3;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CNT_INIT;
                    state_d   = S_CALC;
                    if (is_div) begin
                        opb_d = b_mag;
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        // Special cases preload {remainder, quotient} and go straight to FIX.
                        if (div_zero) begin
                            acc_d     = {op_a, {XLEN{1'b1}}};
                            neg_quo_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = S_FIX;
                        end else if (div_ovf) begin
                            acc_d     = {{XLEN{1'b0}}, op_a};
                            neg_quo_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = S_FIX;
                        end
                    end else begin
                        opb_d = a_mag;
                        acc_d = {{XLEN{1'b0}}, b_mag};
                    end
                end
            end
            S_CALC: begin
                for (int i = 0; i < UNROLL; i++) begin
                    if (op_q[2]) begin
                        rr = {p[2*XLEN-1:XLEN], p[XLEN-1]};
                        if (rr >= {1'b0, opb_q})
                            p = {rr[XLEN-1:0] - opb_q, p[XLEN-2:0], 1'b1};
                        else
                            p = {rr[XLEN-1:0], p[XLEN-2:0], 1'b0};
                    end else begin
                        sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, opb_q} : '0);
                        p   = {sum, p[XLEN-1:1]};
                    end
                end
                acc_d = p;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    3'b000:                 result_d = prod[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = quo;
                    default:                result_d = rem;
                endcase
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign stall  = busy_q | accept;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit attached to the EX stage of the 5-stage pipeline.
- Parametrised in operand width and in bits retired per iteration.
- Raises a stall request so the hazard logic freezes PC, IF/ID and ID/EX while an operation is in flight.
- Accepts a flush so that a taken branch in EX can squash the operation.

Parameters:
XLEN, 32, operand/result width; even, >= 8
UNROLL, 1, bits processed per CALC cycle; one of 1, 2, 4; must divide XLEN

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled when unit is idle
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (already forwarded)
op_b  input  XLEN  rs2 value (already forwarded)
flush  input  1  abort the current/requested operation
stall  output  1  combinational; pipeline must hold while 1
busy  output  1  registered; operation in progress
done  output  1  registered; one-cycle pulse, result valid
result  output  XLEN  registered; held until next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, result=0, all internal accumulators/counters cleared.
- Reset mid-operation: the operation is abandoned silently and no done is produced.
- States: IDLE, CALC, FIX, DONE. Define N = XLEN/UNROLL.
- Accept rule: start=1 & flush=0 in IDLE or DONE latches funct3, op_a and op_b.
- Start while busy=1: ignored.
- Start in DONE: a back-to-back start is accepted in the same cycle that done=1.
- IDLE/DONE -> CALC: normal ops. Iteration counter loaded with N-1.
- IDLE/DONE -> FIX: fast path for divide/remainder by zero and signed overflow; skips CALC.
- CALC:
  - multiply: shift-add on absolute magnitudes, UNROLL bits per cycle into a 2*XLEN accumulator.
  - divide: restoring divide on magnitudes, UNROLL quotient bits per cycle.
  - After N cycles -> FIX.
- FIX, single cycle:
  - Apply sign correction. Product is negated if the operand signs differ: MUL/MULH use both signed, MULHSU treats only op_a as signed. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register result, then -> DONE.
- DONE: done=1 for exactly this cycle, then -> IDLE unless a new start is accepted.
- Latency: with the start edge at T, done=1 during cycle T+N+2; fast path gives done during T+2.
- busy: 1 in CALC and FIX; 0 in IDLE and DONE.
- stall = busy | (start & ~flush & state in {IDLE, DONE}).
- Special cases (match RISC-V spec):
  - Division by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow, DIV with op_a = -2^(XLEN-1) and op_b = -1: quotient = op_a, remainder = 0.
- flush: takes priority over start and over every state. The next edge goes to IDLE with busy=0, no done pulse, and result unchanged.
- Simultaneous flush and FIX -> DONE transition: flush wins; done is not asserted.
- Operands are not re-sampled after acceptance, so op_a/op_b may change while busy.

Test Plan:
1. XLEN=32, UNROLL=1; MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done=1 exactly at T+34, stall=1 from cycle T through T+33.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
3. DIVU 100/7 -> 14; REMU -> 2. REM op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFF. Issue DIVU then REMU back-to-back with start asserted in the done cycle; both must complete with no idle cycle between them.
4. DIV 0x12345678/0 -> 0xFFFFFFFF and REM x/0 -> 0x12345678, each with done at T+2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with REM of the same operands -> 0, also done at T+2.
5. Start DIV, assert flush at T+10 -> busy=0 at T+11, no done pulse, result keeps its previous value. Pull rst low at T+5 of a new op -> all outputs 0 immediately.
6. UNROLL=4: DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF with done at T+10. XLEN=16, UNROLL=2: MUL 0x00FF x 0x0101 -> 0xFFFF with done at T+10.
